lcd_win_ctrl: RTL and testbench

//  Parametrised image display controller: loads an IMG_W x IMG_H frame into local storage, then streams a
//  WIN x WIN view (fit/subsampled or zoomed window) in raster order. Adds input/output handshakes, and H/V mirroring.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_addr_gen.sv | 47 ++++
 rtl/lcd_win_ctrl.sv | 129 ++++++++++++
 tb/tb_lcd_win_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - command codes, FSM states and view modes for the LCD window controller
package lcd_pkg;

   localparam logic [3:0] CMD_REFLASH  = 4'd0;
   localparam logic [3:0] CMD_LOAD     = 4'd1;
   localparam logic [3:0] CMD_ZOOM_IN  = 4'd2;
   localparam logic [3:0] CMD_ZOOM_OUT = 4'd3;
   localparam logic [3:0] CMD_RIGHT    = 4'd4;
   localparam logic [3:0] CMD_LEFT     = 4'd5;
   localparam logic [3:0] CMD_UP       = 4'd6;
   localparam logic [3:0] CMD_DOWN     = 4'd7;
   localparam logic [3:0] CMD_MIRROR_H = 4'd8;
   localparam logic [3:0] CMD_MIRROR_V = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_OUT
   } state_t;

   typedef enum logic {
      MODE_FIT,
      MODE_ZOOM
   } mode_t;

endpackage

// File: rtl/lcd_addr_gen.sv
// rtl/lcd_addr_gen.sv - maps a window beat index to a linear frame address
module lcd_addr_gen
   import lcd_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int WIN   = 4,
   localparam int KW   = 2 * $clog2(WIN),
   localparam int XW   = $clog2(IMG_W),
   localparam int YW   = $clog2(IMG_H),
   localparam int CW   = XW + YW
) (
   input  logic [KW-1:0] k,
   input  mode_t         mode,
   input  logic [XW-1:0] origin_x,
   input  logic [YW-1:0] origin_y,
   input  logic          mirror_h,
   input  logic          mirror_v,
   output logic [CW-1:0] addr
);

   localparam int WW    = KW / 2;
   localparam int XSTEP = IMG_W / WIN;
   localparam int YSTEP = IMG_H / WIN;

   logic [WW-1:0] r, c, rr, cc;
   logic [YW-1:0] row;
   logic [XW-1:0] col;

   // Split beat index into window row/col, apply mirroring, then scale (FIT) or offset (ZOOM).
   // Image dimensions are powers of two, so the linear address is just {row, col}.
   always_comb begin
      r  = k[KW-1:WW];
      c  = k[WW-1:0];
      rr = mirror_v ? (WW'(WIN - 1) - r) : r;
      cc = mirror_h ? (WW'(WIN - 1) - c) : c;
      if (mode == MODE_ZOOM) begin
         row = origin_y + YW'(rr);
         col = origin_x + XW'(cc);
      end else begin
         row = YW'(int'(rr) * YSTEP);
         col = XW'(int'(cc) * XSTEP);
      end
      addr = {row, col};
   end

endmodule

// File: rtl/lcd_win_ctrl.sv
// rtl/lcd_win_ctrl.sv - frame loader and windowed raster streamer for an LCD driver
module lcd_win_ctrl
   import lcd_pkg::*;
#(
   parameter int DW    = 8,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int WIN   = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    cmd,
   input  logic          cmd_valid,
   input  logic [DW-1:0] datain,
   input  logic          datain_valid,
   output logic [DW-1:0] dataout,
   output logic          output_valid,
   input  logic          output_ready,
   output logic          busy
);

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CW    = $clog2(NPIX);
   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int KW    = 2 * $clog2(WIN);
   localparam int NBEAT = WIN * WIN;
   localparam int XMAX  = IMG_W - WIN;
   localparam int YMAX  = IMG_H - WIN;

   state_t        state;
   mode_t         mode;
   logic [CW-1:0] counter;
   logic [XW-1:0] origin_x;
   logic [YW-1:0] origin_y;
   logic          mirror_h;
   logic          mirror_v;
   logic [CW-1:0] rd_addr;

   logic [DW-1:0] mem [NPIX];

   lcd_addr_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .WIN   (WIN)
   ) u_addr_gen (
      .k        (counter[KW-1:0]),
      .mode     (mode),
      .origin_x (origin_x),
      .origin_y (origin_y),
      .mirror_h (mirror_h),
      .mirror_v (mirror_v),
      .addr     (rd_addr)
   );

   // Frame storage is deliberately unreset; a reset mid-load leaves written pixels in place.
   always_ff @(posedge clk) begin
      if (state == ST_LOAD && datain_valid)
         mem[counter] <= datain;
   end

   // Control FSM: command decode in IDLE, pixel counting in LOAD, beat counting in OUT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         mode     <= MODE_FIT;
         counter  <= '0;
         origin_x <= '0;
         origin_y <= '0;
         mirror_h <= 1'b0;
         mirror_v <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               counter <= '0;
               if (cmd_valid) begin
                  state <= (cmd == CMD_LOAD) ? ST_LOAD : ST_OUT;
                  case (cmd)
                     CMD_ZOOM_IN: begin
                        mode     <= MODE_ZOOM;
                        origin_x <= XW'(XMAX / 2);
                        origin_y <= YW'(YMAX / 2);
                     end
                     CMD_ZOOM_OUT: mode <= MODE_FIT;
                     CMD_RIGHT: if (mode == MODE_ZOOM && origin_x != XW'(XMAX)) origin_x <= origin_x + 1'b1;
                     CMD_LEFT:  if (mode == MODE_ZOOM && origin_x != '0)        origin_x <= origin_x - 1'b1;
                     CMD_UP:    if (mode == MODE_ZOOM && origin_y != '0)        origin_y <= origin_y - 1'b1;
                     CMD_DOWN:  if (mode == MODE_ZOOM && origin_y != YW'(YMAX)) origin_y <= origin_y + 1'b1;
                     CMD_MIRROR_H: mirror_h <= ~mirror_h;
                     CMD_MIRROR_V: mirror_v <= ~mirror_v;
                     default: ;
                  endcase
               end
            end
            ST_LOAD: begin
               if (datain_valid) begin
                  if (counter == CW'(NPIX - 1)) begin
                     counter  <= '0;
                     state    <= ST_OUT;
                     mode     <= MODE_FIT;
                     origin_x <= '0;
                     origin_y <= '0;
                     mirror_h <= 1'b0;
                     mirror_v <= 1'b0;
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
            end
            ST_OUT: begin
               if (output_ready) begin
                  if (counter == CW'(NBEAT - 1)) begin
                     counter <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = (state != ST_IDLE);
   assign output_valid = (state == ST_OUT);
   assign dataout      = output_valid ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// tb/tb_lcd_win_ctrl.sv - scoreboard bench for the LCD window controller
module tb_lcd_win_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [7:0] datain;
   logic       datain_valid;
   logic [7:0] dataout;
   logic       output_valid;
   logic       output_ready;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb [$];
   logic [7:0] ref_mem [64];
   logic [7:0] beat_log [16];
   int         log_n;
   bit         m_zoom, m_mh, m_mv;
   int         m_ox, m_oy;

   always #5 clk = ~clk;

   lcd_win_ctrl #(.DW(8), .IMG_W(8), .IMG_H(8), .WIN(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd          (cmd),
      .cmd_valid    (cmd_valid),
      .datain       (datain),
      .datain_valid (datain_valid),
      .dataout      (dataout),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .busy         (busy)
   );

   // Scoreboard consumer: every accepted beat is popped and compared.
   always @(negedge clk) begin
      logic [7:0] exp_v;
      if (!reset && output_valid && output_ready) begin
         if (log_n < 16) beat_log[log_n] = dataout;
         log_n++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected got %0d expected no beat", dataout);
         end else begin
            exp_v = sb.pop_front();
            if (dataout !== exp_v) begin
               errors++;
               $display("FAIL beat_data got %0d expected %0d", dataout, exp_v);
            end
         end
      end
   end

   task automatic push_view();
      for (int k = 0; k < 16; k++) begin
         int r, c, rr, cc, row, col;
         r   = k / 4;
         c   = k % 4;
         rr  = m_mv ? 3 - r : r;
         cc  = m_mh ? 3 - c : c;
         row = m_zoom ? m_oy + rr : rr * 2;
         col = m_zoom ? m_ox + cc : cc * 2;
         sb.push_back(ref_mem[row * 8 + col]);
      end
   endtask

   task automatic model_clear();
      m_zoom = 0; m_mh = 0; m_mv = 0; m_ox = 0; m_oy = 0;
   endtask

   task automatic model_cmd(input logic [3:0] c);
      case (c)
         4'd2: begin m_zoom = 1; m_ox = 2; m_oy = 2; end
         4'd3: m_zoom = 0;
         4'd4: if (m_zoom && m_ox < 4) m_ox++;
         4'd5: if (m_zoom && m_ox > 0) m_ox--;
         4'd6: if (m_zoom && m_oy > 0) m_oy--;
         4'd7: if (m_zoom && m_oy < 4) m_oy++;
         4'd8: m_mh = !m_mh;
         4'd9: m_mv = !m_mv;
         default: ;
      endcase
   endtask

   task automatic send_cmd(input logic [3:0] c);
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin @(negedge clk); n++; end
      if (busy) begin
         checks++; errors++;
         $display("FAIL cmd_wait_idle busy=%0d expected 0", busy);
      end
      log_n = 0;
      cmd = c;
      cmd_valid = 1'b1;
      if (c != 4'd1) begin
         model_cmd(c);
         push_view();
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 400) begin @(negedge clk); n++; end
      checks++;
      if (busy || sb.size() != 0) begin
         errors++;
         $display("FAIL done_timeout busy=%0d pending=%0d expected 0 0", busy, sb.size());
         sb.delete();
      end
   endtask

   task automatic do_load(input bit stall);
      send_cmd(4'd1);
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i);
      model_clear();
      push_view();
      for (int i = 0; i < 64; i++) begin
         datain = 8'(i);
         datain_valid = 1'b1;
         @(posedge clk); #1;
         if (stall && i < 63) begin
            datain_valid = 1'b0;
            cmd_valid = 1'b1;
            cmd = 4'd2;
            @(negedge clk);
            if (i == 62) begin
               checks++;
               if (output_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL load_stall_hold output_valid=%0d expected 0", output_valid);
               end
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
         end
      end
      datain_valid = 1'b0;
      wait_done();
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd = '0; cmd_valid = 0; datain = '0; datain_valid = 0; output_ready = 1;
      log_n = 0;
      model_clear();
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || output_valid !== 1'b0 || dataout !== 8'd0) begin
         errors++;
         $display("FAIL reset_state busy=%0d valid=%0d data=%0d expected 0 0 0", busy, output_valid, dataout);
      end
      reset = 1'b0;
   endtask

   task automatic test_load_fit();
      do_load(1'b0);
      checks++;
      if (beat_log[4] !== 8'd16 || beat_log[15] !== 8'd54) begin
         errors++;
         $display("FAIL fit_view beat4=%0d beat15=%0d expected 16 54", beat_log[4], beat_log[15]);
      end
   endtask

   task automatic test_refresh_timing();
      send_cmd(4'd0);
      repeat (16) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || output_valid !== 1'b1) begin
         errors++;
         $display("FAIL last_beat_busy busy=%0d valid=%0d expected 1 1", busy, output_valid);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || output_valid !== 1'b0 || dataout !== 8'd0) begin
         errors++;
         $display("FAIL after_last_beat busy=%0d valid=%0d data=%0d expected 0 0 0", busy, output_valid, dataout);
      end
      wait_done();
      send_cmd(4'd12);
      wait_done();
   endtask

   task automatic test_zoom_shift();
      send_cmd(4'd2);
      wait_done();
      checks++;
      if (beat_log[0] !== 8'd18 || beat_log[15] !== 8'd45) begin
         errors++;
         $display("FAIL zoom_view first=%0d last=%0d expected 18 45", beat_log[0], beat_log[15]);
      end
      for (int i = 0; i < 3; i++) begin send_cmd(4'd4); wait_done(); end
      checks++;
      if (beat_log[0] !== 8'd20 || beat_log[15] !== 8'd47) begin
         errors++;
         $display("FAIL shift_saturate first=%0d last=%0d expected 20 47", beat_log[0], beat_log[15]);
      end
      for (int i = 0; i < 3; i++) begin send_cmd(4'd7); wait_done(); end
      for (int i = 0; i < 5; i++) begin send_cmd(4'd5); wait_done(); end
      send_cmd(4'd6); wait_done();
      send_cmd(4'd3); wait_done();
      send_cmd(4'd4); wait_done();
   endtask

   task automatic test_mirror();
      send_cmd(4'd2); wait_done();
      send_cmd(4'd8); wait_done();
      checks++;
      if (beat_log[0] !== 8'd21 || beat_log[3] !== 8'd18) begin
         errors++;
         $display("FAIL mirror_h row0 first=%0d fourth=%0d expected 21 18", beat_log[0], beat_log[3]);
      end
      send_cmd(4'd9); wait_done();
      checks++;
      if (beat_log[0] !== 8'd45 || beat_log[3] !== 8'd42) begin
         errors++;
         $display("FAIL mirror_hv row0 first=%0d fourth=%0d expected 45 42", beat_log[0], beat_log[3]);
      end
      send_cmd(4'd3); wait_done();
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      send_cmd(4'd0);
      repeat (3) @(posedge clk);
      #1 output_ready = 1'b0;
      held = sb[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (dataout !== held || output_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_hold data=%0d valid=%0d expected %0d 1", dataout, output_valid, held);
         end
      end
      output_ready = 1'b1;
      wait_done();
   endtask

   task automatic test_reset_mid_out();
      send_cmd(4'd0);
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || output_valid !== 1'b0 || dataout !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_out busy=%0d valid=%0d data=%0d expected 0 0 0", busy, output_valid, dataout);
      end
      sb.delete();
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      send_cmd(4'd0);
      wait_done();
      checks++;
      if (log_n !== 16) begin
         errors++;
         $display("FAIL reset_recover_beats got %0d expected 16", log_n);
      end
   endtask

   initial begin
      test_reset();
      test_load_fit();
      test_refresh_timing();
      test_zoom_shift();
      test_mirror();
      do_load(1'b1);
      test_backpressure();
      test_reset_mid_out();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
